// File: rtl/fb_pkg.sv
// -----------------------------------------------------------------------------
// fb_pkg
// Shared definitions for the framebuffer block:
//   - default geometry (160x120, 3 bits per pixel)
//   - clear-engine state encoding
// Optional build macro used by the framebuffer: FB_DBUF_EN (double buffering).
// -----------------------------------------------------------------------------
package fb_pkg;

  localparam int FB_WIDTH  = 160;
  localparam int FB_HEIGHT = 120;
  localparam int FB_PIX_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_t;

endpackage

// File: rtl/fb_addr_gen.sv
// -----------------------------------------------------------------------------
// fb_addr_gen
// Combinational coordinate-to-address translation with bounds check.
// Ports:
//   i_x         in   XW  x coordinate
//   i_y         in   YW  y coordinate
//   o_addr      out  AW  linear address y*WIDTH + x
//   o_in_bounds out  1   high when x < WIDTH and y < HEIGHT
// -----------------------------------------------------------------------------
module fb_addr_gen
  import fb_pkg::*;
#(
  parameter int WIDTH  = FB_WIDTH,
  parameter int HEIGHT = FB_HEIGHT,
  parameter int XW     = $clog2(WIDTH),
  parameter int YW     = $clog2(HEIGHT),
  parameter int AW     = $clog2(WIDTH * HEIGHT)
) (
  input  logic [XW-1:0] i_x,
  input  logic [YW-1:0] i_y,
  output logic [AW-1:0] o_addr,
  output logic          o_in_bounds
);

  localparam logic [AW-1:0] WIDTH_A = AW'(WIDTH);

  logic [AW-1:0] w_x_ext;
  logic [AW-1:0] w_y_ext;

  // Widen both operands before the multiply so the product is formed in
  // address width rather than coordinate width.
  assign w_x_ext     = AW'(i_x);
  assign w_y_ext     = AW'(i_y);
  assign o_addr      = (w_y_ext * WIDTH_A) + w_x_ext;
  assign o_in_bounds = (int'(i_x) < WIDTH) && (int'(i_y) < HEIGHT);

endmodule

// File: rtl/fb_ram.sv
// -----------------------------------------------------------------------------
// fb_ram
// Single-clock (x,y)-addressed framebuffer, one pixel per word, with bounds
// checking, a one-pixel-per-cycle hardware clear engine and optional double
// buffering (build macro FB_DBUF_EN).
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   wr_x, wr_y, wr_data, wr_en  write port; accepted when wr_ready=1
//   wr_ready                    low while the clear engine owns the memory
//   rd_x, rd_y, rd_en           read request (1-cycle latency)
//   rd_data, rd_valid           read result; out-of-bounds reads return 0
//   clr_req, clr_color          start a fill (sampled in IDLE only)
//   clr_busy, clr_done          clear in progress / one-cycle completion pulse
//   swap_req, frame_start       (FB_DBUF_EN) request bank swap / frame strobe
//   swap_pending, front_sel     (FB_DBUF_EN) swap waiting / displayed bank
// -----------------------------------------------------------------------------
module fb_ram
  import fb_pkg::*;
#(
  parameter int WIDTH  = FB_WIDTH,
  parameter int HEIGHT = FB_HEIGHT,
  parameter int PIX_W  = FB_PIX_W,
  parameter int XW     = $clog2(WIDTH),
  parameter int YW     = $clog2(HEIGHT),
  parameter int DEPTH  = WIDTH * HEIGHT,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XW-1:0]    wr_x,
  input  logic [YW-1:0]    wr_y,
  input  logic [PIX_W-1:0] wr_data,
  input  logic             wr_en,
  output logic             wr_ready,
  input  logic [XW-1:0]    rd_x,
  input  logic [YW-1:0]    rd_y,
  input  logic             rd_en,
  output logic [PIX_W-1:0] rd_data,
  output logic             rd_valid,
  input  logic             clr_req,
  input  logic [PIX_W-1:0] clr_color,
  output logic             clr_busy,
  output logic             clr_done
`ifdef FB_DBUF_EN
  ,
  input  logic             swap_req,
  input  logic             frame_start,
  output logic             swap_pending,
  output logic             front_sel
`endif
);

`ifdef FB_DBUF_EN
  localparam int MDEPTH = 2 * DEPTH;
  localparam int MW     = AW + 1;
`else
  localparam int MDEPTH = DEPTH;
  localparam int MW     = AW;
`endif

  clr_state_t       r_state;
  logic [AW-1:0]    r_cnt;
  logic [PIX_W-1:0] r_clr_color;
  logic             r_clr_busy;
  logic             r_clr_done;
  logic             r_wr_ready;
  logic             r_rd_valid;
  logic             r_rd_zero;
  logic [PIX_W-1:0] r_rd_q;

  logic [PIX_W-1:0] r_mem [MDEPTH];

  logic [AW-1:0]    w_wr_addr;
  logic             w_wr_inb;
  logic [AW-1:0]    w_rd_addr;
  logic             w_rd_inb;
  logic             w_clearing;
  logic             w_mem_we;
  logic             w_rd_hit;
  logic [AW-1:0]    w_wr_local;
  logic [PIX_W-1:0] w_wr_pix;
  logic [MW-1:0]    w_wr_base;
  logic [MW-1:0]    w_rd_base;
  logic [MW-1:0]    w_mem_waddr;
  logic [MW-1:0]    w_mem_raddr;

  fb_addr_gen #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT),
    .XW    (XW),
    .YW    (YW),
    .AW    (AW)
  ) u_wr_addr (
    .i_x        (wr_x),
    .i_y        (wr_y),
    .o_addr     (w_wr_addr),
    .o_in_bounds(w_wr_inb)
  );

  fb_addr_gen #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT),
    .XW    (XW),
    .YW    (YW),
    .AW    (AW)
  ) u_rd_addr (
    .i_x        (rd_x),
    .i_y        (rd_y),
    .o_addr     (w_rd_addr),
    .o_in_bounds(w_rd_inb)
  );

`ifdef FB_DBUF_EN
  logic r_swap_pending;
  logic r_front_sel;

  // Bank 1 lives at offset DEPTH; writes/clear go to the back bank.
  assign w_wr_base = r_front_sel ? '0 : MW'(DEPTH);
  assign w_rd_base = r_front_sel ? MW'(DEPTH) : '0;

  // A pending swap is applied on a frame boundary only when no clear runs,
  // so scan-out never flips to a half-filled bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_swap_pending <= 1'b0;
      r_front_sel    <= 1'b0;
    end else if (frame_start && r_swap_pending && (r_state == IDLE)) begin
      r_front_sel    <= ~r_front_sel;
      r_swap_pending <= 1'b0;
    end else if (swap_req) begin
      r_swap_pending <= 1'b1;
    end
  end

  assign swap_pending = r_swap_pending;
  assign front_sel    = r_front_sel;
`else
  assign w_wr_base = '0;
  assign w_rd_base = '0;
`endif

  // The clear engine owns the write port while in CLEAR; user writes are
  // additionally blocked through wr_ready during CLEAR and DONE.
  assign w_clearing  = (r_state == CLEAR);
  assign w_mem_we    = w_clearing || (wr_en && r_wr_ready && w_wr_inb);
  assign w_wr_local  = w_clearing ? r_cnt : w_wr_addr;
  assign w_wr_pix    = w_clearing ? r_clr_color : wr_data;
  assign w_mem_waddr = MW'(w_wr_local) + w_wr_base;
  assign w_mem_raddr = MW'(w_rd_addr) + w_rd_base;
  assign w_rd_hit    = rd_en && w_rd_inb;

  // Memory array: no reset, read-first on same-address collisions.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_waddr] <= w_wr_pix;
    end
    if (w_rd_hit) begin
      r_rd_q <= r_mem[w_mem_raddr];
    end
  end

  // r_rd_zero forces rd_data to 0 after reset and for out-of-bounds reads,
  // keeping the RAM output register itself free of reset logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_zero  <= 1'b1;
    end else if (rd_en) begin
      r_rd_valid <= 1'b1;
      r_rd_zero  <= ~w_rd_inb;
    end else begin
      r_rd_valid <= 1'b0;
    end
  end

  assign rd_data  = r_rd_zero ? '0 : r_rd_q;
  assign rd_valid = r_rd_valid;

  // Clear engine: IDLE -> CLEAR (DEPTH writes) -> DONE (pulse) -> IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_clr_color <= '0;
      r_clr_busy  <= 1'b0;
      r_clr_done  <= 1'b0;
      r_wr_ready  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (clr_req) begin
            r_clr_color <= clr_color;
            r_cnt       <= '0;
            r_state     <= CLEAR;
            r_clr_busy  <= 1'b1;
            r_wr_ready  <= 1'b0;
          end
        end
        CLEAR: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == AW'(DEPTH - 1)) begin
            r_state    <= DONE;
            r_clr_done <= 1'b1;
          end
        end
        DONE: begin
          r_clr_done <= 1'b0;
          r_clr_busy <= 1'b0;
          r_wr_ready <= 1'b1;
          r_state    <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign clr_busy = r_clr_busy;
  assign clr_done = r_clr_done;
  assign wr_ready = r_wr_ready;

endmodule

// File: tb/tb_fb_ram.sv
// -----------------------------------------------------------------------------
// tb_fb_ram
// Self-checking bench for fb_ram at the default 160x120x3 geometry.
// Read expectations come from a bench-side pixel model and are queued when a
// read is issued, then popped when the result appears.
// With FB_DBUF_EN defined, the bank-swap scenario runs instead of the
// single-bank scenarios.
// -----------------------------------------------------------------------------
module tb_fb_ram;

  localparam int W     = 160;
  localparam int H     = 120;
  localparam int P     = 3;
  localparam int XW    = 8;
  localparam int YW    = 7;
  localparam int DEPTH = W * H;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [XW-1:0] wr_x;
  logic [YW-1:0] wr_y;
  logic [P-1:0]  wr_data;
  logic          wr_en;
  logic          wr_ready;
  logic [XW-1:0] rd_x;
  logic [YW-1:0] rd_y;
  logic          rd_en;
  logic [P-1:0]  rd_data;
  logic          rd_valid;
  logic          clr_req;
  logic [P-1:0]  clr_color;
  logic          clr_busy;
  logic          clr_done;
`ifdef FB_DBUF_EN
  logic          swap_req;
  logic          frame_start;
  logic          swap_pending;
  logic          front_sel;
`endif

  logic [P-1:0] ref_mem [DEPTH];
  logic [P-1:0] sb_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fb_ram dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_x       (wr_x),
    .wr_y       (wr_y),
    .wr_data    (wr_data),
    .wr_en      (wr_en),
    .wr_ready   (wr_ready),
    .rd_x       (rd_x),
    .rd_y       (rd_y),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .clr_req    (clr_req),
    .clr_color  (clr_color),
    .clr_busy   (clr_busy),
    .clr_done   (clr_done)
`ifdef FB_DBUF_EN
    ,
    .swap_req    (swap_req),
    .frame_start (frame_start),
    .swap_pending(swap_pending),
    .front_sel   (front_sel)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    clr_req = 1'b0;
`ifdef FB_DBUF_EN
    swap_req    = 1'b0;
    frame_start = 1'b0;
`endif
  endtask

  // Drive a write for the next edge and mirror it into the model when it is
  // inside the frame (callers use this only while the clear engine is idle).
  task automatic set_write(input int x, input int y, input logic [P-1:0] d);
    wr_x    = x[XW-1:0];
    wr_y    = y[YW-1:0];
    wr_data = d;
    wr_en   = 1'b1;
    if (x < W && y < H) ref_mem[y * W + x] = d;
  endtask

  // Drive a read for the next edge and queue the expected pixel.
  task automatic set_read(input int x, input int y);
    rd_x  = x[XW-1:0];
    rd_y  = y[YW-1:0];
    rd_en = 1'b1;
    if (x < W && y < H) sb_q.push_back(ref_mem[y * W + x]);
    else                sb_q.push_back('0);
  endtask

  task automatic test_power_on();
    n_checks++;
    if (rd_valid !== 1'b0) $display("FAIL por_rd_valid: got %b want 0", rd_valid);
    else n_pass++;
    n_checks++;
    if (rd_data !== 3'b000) $display("FAIL por_rd_data: got %b want 000", rd_data);
    else n_pass++;
    n_checks++;
    if (wr_ready !== 1'b1 || clr_busy !== 1'b0 || clr_done !== 1'b0)
      $display("FAIL por_ctrl: got ready=%b busy=%b done=%b want 1 0 0", wr_ready, clr_busy, clr_done);
    else n_pass++;
  endtask

  task automatic test_write_read();
    logic [P-1:0] exp;
    set_write(5, 2, 3'b101);
    step();
    wr_en = 1'b0;
    set_read(5, 2);
    step();
    rd_en = 1'b0;
    exp = sb_q.pop_front();
    n_checks++;
    if (rd_valid !== 1'b1) $display("FAIL wr_rd_valid: got %b want 1", rd_valid);
    else n_pass++;
    n_checks++;
    if (rd_data !== exp) $display("FAIL wr_rd_data: got %b want %b", rd_data, exp);
    else n_pass++;
    step();
    n_checks++;
    if (rd_valid !== 1'b0) $display("FAIL rd_valid_pulse: got %b want 0", rd_valid);
    else n_pass++;
    n_checks++;
    if (rd_data !== exp) $display("FAIL rd_data_hold: got %b want %b", rd_data, exp);
    else n_pass++;
  endtask

  task automatic test_bounds();
    logic [P-1:0] exp;
    set_write(0, 1, 3'b011);
    step();
    set_write(160, 0, 3'b111);   // aliases (0,1) if x is not bounds-checked
    step();
    set_write(0, 120, 3'b110);
    step();
    wr_en = 1'b0;
    set_read(0, 1);
    step();
    exp = sb_q.pop_front();
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== exp)
      $display("FAIL oob_keep_0_1: got v=%b d=%b want v=1 d=%b", rd_valid, rd_data, exp);
    else n_pass++;
    set_read(160, 0);
    step();
    exp = sb_q.pop_front();
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== exp)
      $display("FAIL oob_read_x: got v=%b d=%b want v=1 d=%b", rd_valid, rd_data, exp);
    else n_pass++;
    set_read(255, 127);
    step();
    exp = sb_q.pop_front();
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== exp)
      $display("FAIL oob_read_xy: got v=%b d=%b want v=1 d=%b", rd_valid, rd_data, exp);
    else n_pass++;
    set_read(5, 2);
    step();
    rd_en = 1'b0;
    exp = sb_q.pop_front();
    n_checks++;
    if (rd_data !== exp) $display("FAIL back_to_back_5_2: got %b want %b", rd_data, exp);
    else n_pass++;
  endtask

  task automatic test_collision();
    logic [P-1:0] exp;
    set_write(7, 7, 3'b001);
    step();
    set_read(7, 7);              // queued before the new write updates the model
    set_write(7, 7, 3'b110);
    step();
    wr_en = 1'b0;
    exp = sb_q.pop_front();
    n_checks++;
    if (rd_data !== exp) $display("FAIL collide_old: got %b want %b", rd_data, exp);
    else n_pass++;
    set_read(7, 7);
    step();
    rd_en = 1'b0;
    exp = sb_q.pop_front();
    n_checks++;
    if (rd_data !== exp) $display("FAIL collide_new: got %b want %b", rd_data, exp);
    else n_pass++;
  endtask

  task automatic test_clear();
    int busy_cnt = 0;
    int done_cnt = 0;
    int done_at  = 0;
    int ready_bad = 0;
    int bad = 0;
    int first_bad = -1;
    logic [P-1:0] exp;
    clr_color = 3'b010;
    clr_req   = 1'b1;
    step();
    clr_req   = 1'b0;
    clr_color = 3'b111;
    while (clr_busy === 1'b1 && busy_cnt < 20000) begin
      busy_cnt++;
      if (clr_done === 1'b1) begin
        done_cnt++;
        done_at = busy_cnt;
      end
      if (wr_ready !== 1'b0) ready_bad++;
      wr_en   = 1'b0;
      clr_req = 1'b0;
      if (busy_cnt == 100) begin
        // (10,0) is already cleared by now, so a leaked write would survive.
        wr_x = 8'd10; wr_y = 7'd0; wr_data = 3'b101; wr_en = 1'b1;
      end
      if (busy_cnt == 200) clr_req = 1'b1;
      step();
    end
    wr_en   = 1'b0;
    clr_req = 1'b0;
    n_checks++;
    if (busy_cnt != DEPTH + 1) $display("FAIL clr_busy_len: got %0d want %0d", busy_cnt, DEPTH + 1);
    else n_pass++;
    n_checks++;
    if (done_cnt != 1 || done_at != DEPTH + 1)
      $display("FAIL clr_done_pulse: got count=%0d at=%0d want 1 at %0d", done_cnt, done_at, DEPTH + 1);
    else n_pass++;
    n_checks++;
    if (ready_bad != 0) $display("FAIL clr_wr_ready: got %0d cycles with wr_ready!=0 want 0", ready_bad);
    else n_pass++;
    n_checks++;
    if (wr_ready !== 1'b1 || clr_done !== 1'b0)
      $display("FAIL clr_after: got ready=%b done=%b want 1 0", wr_ready, clr_done);
    else n_pass++;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 3'b010;
    for (int a = 0; a < DEPTH; a++) begin
      set_read(a % W, a / W);
      step();
      exp = sb_q.pop_front();
      if (rd_valid !== 1'b1 || rd_data !== exp) begin
        if (first_bad < 0) first_bad = a;
        bad++;
      end
    end
    rd_en = 1'b0;
    n_checks++;
    if (bad != 0) $display("FAIL clr_fill: got %0d bad words (first at %0d) want 0", bad, first_bad);
    else n_pass++;
  endtask

  task automatic test_reset();
    int late = 0;
    logic [P-1:0] exp;
    set_write(3, 3, 3'b111);
    step();
    wr_en = 1'b0;
    set_read(3, 3);
    clr_color = 3'b000;
    clr_req   = 1'b1;
    step();
    rd_en   = 1'b0;
    clr_req = 1'b0;
    exp = sb_q.pop_front();
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== exp || clr_busy !== 1'b1)
      $display("FAIL prereset: got v=%b d=%b busy=%b want 1 %b 1", rd_valid, rd_data, clr_busy, exp);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (rd_data !== 3'b000) $display("FAIL rst_rd_data: got %b want 000", rd_data);
    else n_pass++;
    n_checks++;
    if (rd_valid !== 1'b0) $display("FAIL rst_rd_valid: got %b want 0", rd_valid);
    else n_pass++;
    n_checks++;
    if (clr_busy !== 1'b0 || clr_done !== 1'b0)
      $display("FAIL rst_clr: got busy=%b done=%b want 0 0", clr_busy, clr_done);
    else n_pass++;
    n_checks++;
    if (wr_ready !== 1'b1) $display("FAIL rst_wr_ready: got %b want 1", wr_ready);
    else n_pass++;
    #2 rst_n = 1'b1;
    step();
    for (int i = 0; i < 30; i++) begin
      if (clr_done !== 1'b0 || clr_busy !== 1'b0) late++;
      step();
    end
    n_checks++;
    if (late != 0) $display("FAIL rst_abort: got %0d cycles busy/done after abort want 0", late);
    else n_pass++;
    set_read(3, 3);
    step();
    exp = sb_q.pop_front();
    n_checks++;
    if (rd_data !== exp) $display("FAIL rst_mem_kept_3_3: got %b want %b", rd_data, exp);
    else n_pass++;
    set_read(0, 0);
    step();
    rd_en = 1'b0;
    exp = sb_q.pop_front();
    n_checks++;
    if (rd_data !== exp) $display("FAIL rst_mem_kept_0_0: got %b want %b", rd_data, exp);
    else n_pass++;
  endtask

`ifdef FB_DBUF_EN
  task automatic test_dbuf();
    int pend_bad = 0;
    logic [P-1:0] exp;
    set_write(1, 1, 3'b100);
    step();
    wr_en       = 1'b0;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    n_checks++;
    if (front_sel !== 1'b0 || swap_pending !== 1'b0)
      $display("FAIL dbuf_no_swap: got sel=%b pend=%b want 0 0", front_sel, swap_pending);
    else n_pass++;
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (swap_pending !== 1'b1 || front_sel !== 1'b0) pend_bad++;
      step();
    end
    n_checks++;
    if (pend_bad != 0) $display("FAIL dbuf_pending: got %0d bad cycles want 0", pend_bad);
    else n_pass++;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    n_checks++;
    if (front_sel !== 1'b1 || swap_pending !== 1'b0)
      $display("FAIL dbuf_swap: got sel=%b pend=%b want 1 0", front_sel, swap_pending);
    else n_pass++;
    set_read(1, 1);
    step();
    rd_en = 1'b0;
    exp = sb_q.pop_front();
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== exp)
      $display("FAIL dbuf_read: got v=%b d=%b want 1 %b", rd_valid, rd_data, exp);
    else n_pass++;
  endtask
`endif

  initial begin
    rst_n     = 1'b0;
    wr_x      = '0;
    wr_y      = '0;
    wr_data   = '0;
    rd_x      = '0;
    rd_y      = '0;
    clr_color = '0;
    drive_idle();
    #23 rst_n = 1'b1;
    step();
    test_power_on();
`ifdef FB_DBUF_EN
    test_dbuf();
`else
    test_write_read();
    test_bounds();
    test_collision();
    test_clear();
    test_reset();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fb_ram.md
Name: fb_ram

Overview:
- Parametrised single-clock framebuffer, one pixel per word, addressed by (x, y).
- Sits between the game/draw logic (write port) and the display scan-out (read port).
- Adds bounds checking, a one-pixel-per-cycle hardware clear engine with busy/done handshake, and optional double buffering.
- Synchronous single-cycle read, inferable as block RAM.

Parameters:
- WIDTH, 160, pixels per line; x range 0..WIDTH-1
- HEIGHT, 120, lines per frame; y range 0..HEIGHT-1
- PIX_W, 3, bits per pixel
- XW, $clog2(WIDTH), x coordinate width (derived)
- YW, $clog2(HEIGHT), y coordinate width (derived)
- DEPTH, WIDTH*HEIGHT, words per bank (derived)
- AW, $clog2(DEPTH), address width (derived)

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- wr_x  input  XW  write x coordinate
- wr_y  input  YW  write y coordinate
- wr_data  input  PIX_W  write pixel value
- wr_en  input  1  write strobe; accepted only when wr_ready=1
- wr_ready  output  1  high when writes are accepted (low during clear)
- rd_x  input  XW  read x coordinate
- rd_y  input  YW  read y coordinate
- rd_en  input  1  read strobe
- rd_data  output  PIX_W  read pixel, valid with rd_valid
- rd_valid  output  1  pulses one cycle after an accepted rd_en
- clr_req  input  1  start clear; sampled only in IDLE
- clr_color  input  PIX_W  fill value, captured with clr_req
- clr_busy  output  1  clear in progress
- clr_done  output  1  one-cycle pulse when clear completes
- (FB_DBUF_EN only) swap_req  input  1  request front/back exchange
- (FB_DBUF_EN only) frame_start  input  1  display frame boundary strobe
- (FB_DBUF_EN only) swap_pending  output  1  swap requested, not yet applied
- (FB_DBUF_EN only) front_sel  output  1  bank currently scanned out

Behaviour:
- Address = y*WIDTH + x, computed in AW bits; the multiply must not truncate to the coordinate width.
- Reset (async, rst_n=0) sets:
  - rd_data=0, rd_valid=0
  - clr_busy=0, clr_done=0, wr_ready=1
  - FSM=IDLE, clear counter=0
  - swap_pending=0, front_sel=0
- Memory contents are not reset.
- Write: when wr_en=1, wr_ready=1, x<WIDTH and y<HEIGHT, the memory word is updated at the clock edge. Out-of-bounds writes are silently dropped.
- Read latency is 1 cycle. rd_en in cycle N gives rd_valid=1 and rd_data in cycle N+1.
- An out-of-bounds read returns rd_data=0 with rd_valid=1.
- rd_data holds its value when rd_en=0.
- Read and write to the same address in the same cycle: the read returns the old data (read-first).
- Reads are always allowed, including during clear; they return whatever the memory currently holds.
- Clear FSM states:
  - IDLE: clr_req=1 latches clr_color, sets counter=0, goes to CLEAR.
  - CLEAR: writes the latched color at the counter address each cycle, counter+1. At counter=DEPTH-1 it writes, then goes to DONE.
  - DONE: clr_done=1 for one cycle, then IDLE.
- clr_busy=1 and wr_ready=0 in CLEAR and DONE.
- wr_en during a clear is discarded, not queued.
- clr_req outside IDLE is ignored.
- A full clear takes DEPTH cycles of writes; clr_done is asserted DEPTH+1 cycles after the clr_req edge.
- Reset asserted mid-clear aborts to IDLE. The partially cleared memory is left as is, and no clr_done is issued.

Optional Feature:
- Macro FB_DBUF_EN.
- Defined:
  - Two banks of DEPTH words. Writes and the clear engine target the back bank (!front_sel); reads target the front bank.
  - swap_req sets swap_pending.
  - On the first frame_start with swap_pending=1 and FSM=IDLE: front_sel toggles and swap_pending clears.
  - A swap is deferred while a clear is busy.
  - swap_req and frame_start in the same cycle with no pending swap: the swap applies at the next frame_start.
- Undefined: one bank; the swap ports and logic are absent.

Decomposition:
- Shared package fb_pkg holds:
  - default geometry constants FB_WIDTH=160, FB_HEIGHT=120, FB_PIX_W=3
  - the clear-FSM state enum {IDLE, CLEAR, DONE}
- One natural sub-module, fb_addr_gen: combinational x/y bounds check plus y*WIDTH+x address, instanced once for each of the write and read ports.
- Clear FSM and memory array stay in fb_ram.

Test Plan (defaults 160x120, PIX_W=3):
- Assert rst_n=0 mid-simulation -> rd_data=0, rd_valid=0, clr_busy=0, clr_done=0, wr_ready=1 immediately, without waiting for a clock edge.
- Write (5,2)=3'b101, then rd_en (5,2) next cycle -> rd_valid=1 one cycle later with rd_data=3'b101; address 325 checked against a reference model.
- Write (0,1)=3'b011, then write (160,0)=3'b111 (out of bounds) -> a read of (0,1) still returns 3'b011; a read of (160,0) returns 0 with rd_valid=1.
- clr_req with clr_color=3'b010, plus wr_en at cycle 100 of the clear -> clr_busy high for 19201 cycles, clr_done pulses once, every address reads 3'b010, and the cycle-100 write has no effect.
- Same cycle wr_en and rd_en at (7,7), old value 3'b001, new value 3'b110 -> rd_data=3'b001; the following read returns 3'b110.
- FB_DBUF_EN: write 3'b100 to back (1,1), swap_req, then frame_start 10 cycles later -> swap_pending=1 until frame_start, front_sel 0->1, then a read of (1,1) returns 3'b100.
